// File: rtl/cmem_pkg.sv
// cmem_pkg: shared memory-select codes, width defaults and arbiter FSM encoding
package cmem_pkg;
  localparam int CMEM_ADDR_WIDTH = 12;
  localparam int CMEM_DATA_WIDTH = 20;
  localparam logic [2:0] NO_ACCESS = 3'd0;
  localparam logic [2:0] L0_MEM0   = 3'd1;
  localparam logic [2:0] L0_MEM1   = 3'd2;
  localparam logic [2:0] L1_MEM0   = 3'd3;
  localparam logic [2:0] L1_MEM1   = 3'd4;
  localparam logic [2:0] L2_MEM    = 3'd5;
  typedef enum logic {ARB, HOLD} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after the pointer, wrapping, as one-hot grant plus index
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);
  logic [IW-1:0] w_j;
  // scan from the farthest slot back to the pointer so the nearest request wins
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_j]) begin
        o_gnt = '0;
        o_gnt[w_j] = 1'b1;
        o_idx = w_j;
      end
    end
  end
endmodule

// File: rtl/cmem_arbiter.sv
// cmem_arbiter: round-robin, lockable sharing of the layer-memory port with read-data return
module cmem_arbiter
  import cmem_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int ADDR_WIDTH = cmem_pkg::CMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = cmem_pkg::CMEM_DATA_WIDTH,
  parameter int CSEL_WIDTH = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ-1:0]           req_wr,
  input  logic [N_REQ-1:0]           req_lock,
  input  logic [N_REQ*CSEL_WIDTH-1:0] req_csel,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [CSEL_WIDTH-1:0]      csel,
  output logic                       cwr,
  output logic [ADDR_WIDTH-1:0]      caddr_wr,
  output logic [DATA_WIDTH-1:0]      cdata_wr,
  output logic                       crd,
  output logic [ADDR_WIDTH-1:0]      caddr_rd,
  input  logic [DATA_WIDTH-1:0]      cdata_rd,
  output logic                       err_csel
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  arb_state_t r_state, w_state_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt, r_owner, w_owner_nxt, w_idx, w_idx_inc;
  logic [N_REQ-1:0] w_req, w_gnt;
  logic w_fire, w_legal, w_go, w_wr, w_lock;
  logic [CSEL_WIDTH-1:0] w_csel;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [RD_LATENCY:0] r_pv;
  logic [RD_LATENCY:0][IW-1:0] r_pid;
  // while holding, only the owner may compete, so the picker returns it regardless of the pointer
  assign w_req = (r_state == HOLD) ? (req_valid & (N_REQ'(1) << r_owner)) : req_valid;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .i_req(w_req),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx)
  );
  assign req_ready = w_gnt;
  assign w_fire = |w_gnt;
  assign w_idx_inc = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_legal = (w_csel != CSEL_WIDTH'(NO_ACCESS)) && (w_csel <= CSEL_WIDTH'(L2_MEM));
  assign w_go = w_fire && w_legal;
  // select the granted requester's beat fields
  always_comb begin
    w_csel = '0;
    w_addr = '0;
    w_wdata = '0;
    w_wr = 1'b0;
    w_lock = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_csel = req_csel[i*CSEL_WIDTH +: CSEL_WIDTH];
        w_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_wr = req_wr[i];
        w_lock = req_lock[i];
      end
    end
  end
  // lock FSM next state: the pointer freezes while a locked burst continues
  always_comb begin
    w_ptr_nxt = (w_fire && (r_state == ARB || !w_lock)) ? w_idx_inc : r_ptr;
    w_state_nxt = w_fire ? (w_lock ? HOLD : ARB) : r_state;
    w_owner_nxt = w_fire ? w_idx : r_owner;
  end
  // lock FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ARB;
      r_ptr <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end
  // registered memory port, sticky csel error, and read-ID pipeline feeding the response strobe
  always_ff @(posedge clk) begin
    if (!reset) begin
      csel <= '0;
      cwr <= 1'b0;
      crd <= 1'b0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      caddr_rd <= '0;
      err_csel <= 1'b0;
      r_pv <= '0;
      r_pid <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
    end else begin
      csel <= w_go ? w_csel : '0;
      cwr <= w_go && w_wr;
      crd <= w_go && !w_wr;
      caddr_wr <= (w_go && w_wr) ? w_addr : '0;
      cdata_wr <= (w_go && w_wr) ? w_wdata : '0;
      caddr_rd <= (w_go && !w_wr) ? w_addr : '0;
      err_csel <= err_csel | (w_fire && !w_legal);
      r_pv <= {r_pv[RD_LATENCY-1:0], w_go && !w_wr};
      r_pid <= {r_pid[RD_LATENCY-1:0], w_idx};
      rsp_valid <= r_pv[RD_LATENCY] ? (N_REQ'(1) << r_pid[RD_LATENCY]) : '0;
      rsp_data <= r_pv[RD_LATENCY] ? cdata_rd : '0;
    end
  end
endmodule

// File: tb/tb_cmem_arbiter.sv
// tb_cmem_arbiter: directed vector table plus a write-then-read sequence against a memory model
module tb_cmem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] req_valid, req_ready, req_wr, req_lock, rsp_valid;
  logic [2:0] c0, c1, c2;
  logic [11:0] a0, a1, a2;
  logic [19:0] d0, d1, d2;
  logic [8:0] req_csel;
  logic [35:0] req_addr;
  logic [59:0] req_wdata;
  logic [19:0] rsp_data, cdata_wr, cdata_rd;
  logic [11:0] caddr_wr, caddr_rd;
  logic [2:0] csel;
  logic cwr, crd, err_csel;
  logic [19:0] mem [0:4095];
  int errors = 0;
  int checks = 0;
  assign req_csel = {c2, c1, c0};
  assign req_addr = {a2, a1, a0};
  assign req_wdata = {d2, d1, d0};
  cmem_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_lock(req_lock),
    .req_csel(req_csel), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .err_csel(err_csel)
  );
  // memory with one cycle of read latency
  always @(posedge clk) begin
    if (cwr) mem[caddr_wr] <= cdata_wr;
    cdata_rd <= crd ? mem[caddr_rd] : 20'h0;
  end
  typedef struct {
    logic rst_n;
    logic [2:0] v, wr, lk, c2, e_rdy;
    logic e_cwr, e_crd;
    logic [2:0] e_csel;
    logic [11:0] e_addr;
    logic [19:0] e_wd;
    logic [2:0] e_rv;
    logic [19:0] e_rd;
    logic e_err;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic r, logic [2:0] v, logic [2:0] wr, logic [2:0] lk, logic [2:0] c,
                              logic [2:0] rdy, logic cw, logic cr, logic [2:0] cs, logic [11:0] ad,
                              logic [19:0] wd, logic [2:0] rv, logic [19:0] rd, logic er);
    vec_t t;
    t.rst_n = r; t.v = v; t.wr = wr; t.lk = lk; t.c2 = c; t.e_rdy = rdy;
    t.e_cwr = cw; t.e_crd = cr; t.e_csel = cs; t.e_addr = ad; t.e_wd = wd;
    t.e_rv = rv; t.e_rd = rd; t.e_err = er;
    return t;
  endfunction
  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask
  initial begin
    logic got;
    int lat;
    for (int i = 0; i < 4096; i++) mem[i] = 20'h0;
    mem[12'h041] = 20'h0ABCD;
    mem[12'h005] = 20'h12345;
    mem[12'h200] = 20'h54321;
    cdata_rd = 20'h0;
    req_valid = 0; req_wr = 0; req_lock = 0;
    c0 = 3'd1; a0 = 12'h041; d0 = 20'h00A5C;
    c1 = 3'd1; a1 = 12'h005; d1 = 20'h11111;
    c2 = 3'd2; a2 = 12'h200; d2 = 20'h22222;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    //                 rst v      wr     lk     c2 rdy    cw cr cs ad       wd        rv     rd        er
    tbl.push_back(mk(1, 3'b001, 3'b001, 3'b000, 2, 3'b001, 0, 0, 0, 12'h000, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2, 3'b000, 1, 0, 1, 12'h041, 20'h00A5C, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b010, 3'b000, 3'b000, 2, 3'b010, 0, 0, 0, 12'h000, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2, 3'b000, 0, 1, 1, 12'h005, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2, 3'b000, 0, 0, 0, 12'h000, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2, 3'b000, 0, 0, 0, 12'h000, 20'h00000, 3'b010, 20'h12345, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 2, 3'b000, 0, 0, 0, 12'h000, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b111, 3'b101, 3'b000, 2, 3'b001, 0, 0, 0, 12'h000, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b111, 3'b101, 3'b000, 2, 3'b010, 1, 0, 1, 12'h041, 20'h00A5C, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b111, 3'b101, 3'b000, 2, 3'b100, 0, 1, 1, 12'h005, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b111, 3'b101, 3'b000, 2, 3'b001, 1, 0, 2, 12'h200, 20'h22222, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b111, 3'b101, 3'b000, 2, 3'b010, 1, 0, 1, 12'h041, 20'h00A5C, 3'b010, 20'h12345, 0));
    tbl.push_back(mk(1, 3'b111, 3'b101, 3'b000, 2, 3'b100, 0, 1, 1, 12'h005, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2, 3'b000, 1, 0, 2, 12'h200, 20'h22222, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2, 3'b000, 0, 0, 0, 12'h000, 20'h00000, 3'b010, 20'h12345, 0));
    tbl.push_back(mk(1, 3'b001, 3'b000, 3'b000, 2, 3'b001, 0, 0, 0, 12'h000, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b010, 2, 3'b010, 0, 1, 1, 12'h041, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b010, 2, 3'b010, 0, 1, 1, 12'h005, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b010, 2, 3'b010, 0, 1, 1, 12'h005, 20'h00000, 3'b001, 20'h00A5C, 0));
    tbl.push_back(mk(1, 3'b101, 3'b000, 3'b010, 2, 3'b000, 0, 1, 1, 12'h005, 20'h00000, 3'b010, 20'h12345, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b000, 2, 3'b010, 0, 0, 0, 12'h000, 20'h00000, 3'b010, 20'h12345, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b000, 2, 3'b100, 0, 1, 1, 12'h005, 20'h00000, 3'b010, 20'h12345, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b000, 2, 3'b001, 0, 1, 2, 12'h200, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2, 3'b000, 0, 1, 1, 12'h041, 20'h00000, 3'b010, 20'h12345, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2, 3'b000, 0, 0, 0, 12'h000, 20'h00000, 3'b100, 20'h22222, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2, 3'b000, 0, 0, 0, 12'h000, 20'h00000, 3'b001, 20'h00A5C, 0));
    tbl.push_back(mk(1, 3'b100, 3'b100, 3'b000, 7, 3'b100, 0, 0, 0, 12'h000, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2, 3'b000, 0, 0, 0, 12'h000, 20'h00000, 3'b000, 20'h00000, 1));
    tbl.push_back(mk(1, 3'b010, 3'b000, 3'b000, 2, 3'b010, 0, 0, 0, 12'h000, 20'h00000, 3'b000, 20'h00000, 1));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2, 3'b000, 0, 1, 1, 12'h005, 20'h00000, 3'b000, 20'h00000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 2, 3'b000, 0, 0, 0, 12'h000, 20'h00000, 3'b000, 20'h00000, 1));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2, 3'b000, 0, 0, 0, 12'h000, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b000, 2, 3'b001, 0, 0, 0, 12'h000, 20'h00000, 3'b000, 20'h00000, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2, 3'b000, 0, 1, 1, 12'h041, 20'h00000, 3'b000, 20'h00000, 0));
    foreach (tbl[r]) begin
      @(negedge clk);
      reset = tbl[r].rst_n;
      req_valid = tbl[r].v;
      req_wr = tbl[r].wr;
      req_lock = tbl[r].lk;
      c2 = tbl[r].c2;
      #1;
      chk("ready", r, req_ready, tbl[r].e_rdy);
      chk("cwr", r, cwr, tbl[r].e_cwr);
      chk("crd", r, crd, tbl[r].e_crd);
      chk("csel", r, csel, tbl[r].e_csel);
      chk("caddr_wr", r, caddr_wr, tbl[r].e_cwr ? tbl[r].e_addr : 12'h0);
      chk("caddr_rd", r, caddr_rd, tbl[r].e_crd ? tbl[r].e_addr : 12'h0);
      chk("cdata_wr", r, cdata_wr, tbl[r].e_wd);
      chk("rsp_valid", r, rsp_valid, tbl[r].e_rv);
      if (tbl[r].e_rv != 3'b000) chk("rsp_data", r, rsp_data, tbl[r].e_rd);
      chk("err_csel", r, err_csel, tbl[r].e_err);
    end
    @(negedge clk);
    req_valid = 3'b001; req_wr = 3'b001; req_lock = 3'b000; d0 = 20'h0BEEF;
    #1 chk("seq_wr_ready", 100, req_ready, 3'b001);
    @(negedge clk);
    req_wr = 3'b000;
    #1 chk("seq_rd_ready", 101, req_ready, 3'b001);
    chk("seq_cwr", 101, cwr, 1'b1);
    chk("seq_caddr_wr", 101, caddr_wr, 12'h041);
    chk("seq_cdata_wr", 101, cdata_wr, 20'h0BEEF);
    @(negedge clk);
    req_valid = 3'b000;
    #1 chk("seq_crd", 102, crd, 1'b1);
    chk("seq_cwr_off", 102, cwr, 1'b0);
    chk("seq_caddr_rd", 102, caddr_rd, 12'h041);
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      #1;
      if (rsp_valid != 3'b000) begin
        got = 1'b1;
        lat = n;
      end
    end
    chk("seq_rsp_seen", 103, got, 1'b1);
    if (got) begin
      chk("seq_rsp_lat", 103, lat, 2);
      chk("seq_rsp_valid", 103, rsp_valid, 3'b001);
      chk("seq_rsp_data", 103, rsp_data, 20'h0BEEF);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
